// File: rtl/dom_mul_scheduler.sv
// Round-robin issue sequencer sharing one pipelined 2-share DOM GF(2^2) multiplier between two requesters.
// Optional DOM_SCHED_ZERO_IDLE_EN: multiplier inputs are forced to zero in every non-issue cycle.
module dom_mul_scheduler #(
    parameter int TAGW = 4
) (
    input  logic            ClkxCI,
    input  logic            RstxBI,
    input  logic            Req0ValidxSI,
    output logic            Req0ReadyxSO,
    input  logic [3:0]      Req0XxDI,
    input  logic [3:0]      Req0YxDI,
    input  logic [TAGW-1:0] Req0TagxDI,
    input  logic            Req1ValidxSI,
    output logic            Req1ReadyxSO,
    input  logic [3:0]      Req1XxDI,
    input  logic [3:0]      Req1YxDI,
    input  logic [TAGW-1:0] Req1TagxDI,
    output logic            Rsp0ValidxSO,
    input  logic            Rsp0ReadyxSI,
    output logic [3:0]      Rsp0QxDO,
    output logic [TAGW-1:0] Rsp0TagxDO,
    output logic            Rsp1ValidxSO,
    input  logic            Rsp1ReadyxSI,
    output logic [3:0]      Rsp1QxDO,
    output logic [TAGW-1:0] Rsp1TagxDO,
    input  logic            RndValidxSI,
    output logic            RndReadyxSO,
    input  logic [3:0]      RndxDI,
    output logic [3:0]      MulXxDO,
    output logic [3:0]      MulYxDO,
    output logic [1:0]      MulZxDO,
    output logic [1:0]      MulBxDO,
    input  logic [3:0]      MulQxDI
);

    logic            ptrxDP;
    logic            inFltValidxDP;
    logic            inFltDestxDP;
    logic [TAGW-1:0] inFltTagxDP;
    logic            rsp0ValidxDP, rsp1ValidxDP;
    logic [3:0]      rsp0QxDP, rsp1QxDP;
    logic [TAGW-1:0] rsp0TagxDP, rsp1TagxDP;

    logic            elig0xS, elig1xS;
    logic            selxS;
    logic            issuexS;
    logic [3:0]      selXxD, selYxD;
    logic [TAGW-1:0] selTagxD;

    always_comb begin
        elig0xS = Req0ValidxSI & ~(inFltValidxDP & ~inFltDestxDP) & (~rsp0ValidxDP | Rsp0ReadyxSI);
        elig1xS = Req1ValidxSI & ~(inFltValidxDP & inFltDestxDP) & (~rsp1ValidxDP | Rsp1ReadyxSI);
        if (elig0xS && elig1xS) begin
            selxS = ptrxDP;
        end else if (elig0xS) begin
            selxS = 1'b0;
        end else if (elig1xS) begin
            selxS = 1'b1;
        end else begin
            selxS = ptrxDP;
        end
        // Reset gates issue so no ready can fire while the block is held in reset.
        issuexS  = (elig0xS | elig1xS) & RndValidxSI & RstxBI;
        selXxD   = selxS ? Req1XxDI : Req0XxDI;
        selYxD   = selxS ? Req1YxDI : Req0YxDI;
        selTagxD = selxS ? Req1TagxDI : Req0TagxDI;
    end

    assign Req0ReadyxSO = issuexS & ~selxS;
    assign Req1ReadyxSO = issuexS & selxS;
    assign RndReadyxSO  = issuexS;

`ifdef DOM_SCHED_ZERO_IDLE_EN
    always_comb begin
        MulXxDO = issuexS ? selXxD      : 4'd0;
        MulYxDO = issuexS ? selYxD      : 4'd0;
        MulZxDO = issuexS ? RndxDI[1:0] : 2'd0;
        MulBxDO = issuexS ? RndxDI[3:2] : 2'd0;
    end
`else
    always_comb begin
        MulXxDO = RstxBI ? selXxD      : 4'd0;
        MulYxDO = RstxBI ? selYxD      : 4'd0;
        MulZxDO = RstxBI ? RndxDI[1:0] : 2'd0;
        MulBxDO = RstxBI ? RndxDI[3:2] : 2'd0;
    end
`endif

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            ptrxDP        <= 1'b0;
            inFltValidxDP <= 1'b0;
            inFltDestxDP  <= 1'b0;
            inFltTagxDP   <= '0;
        end else begin
            inFltValidxDP <= issuexS;
            if (issuexS) begin
                ptrxDP       <= ~selxS;
                inFltDestxDP <= selxS;
                inFltTagxDP  <= selTagxD;
            end
        end
    end

    // A slot is only ever targeted when it was empty or popped at issue, so capture and pop never collide.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            rsp0ValidxDP <= 1'b0;
            rsp0QxDP     <= '0;
            rsp0TagxDP   <= '0;
            rsp1ValidxDP <= 1'b0;
            rsp1QxDP     <= '0;
            rsp1TagxDP   <= '0;
        end else begin
            if (inFltValidxDP && !inFltDestxDP) begin
                rsp0ValidxDP <= 1'b1;
                rsp0QxDP     <= MulQxDI;
                rsp0TagxDP   <= inFltTagxDP;
            end else if (rsp0ValidxDP && Rsp0ReadyxSI) begin
                rsp0ValidxDP <= 1'b0;
            end
            if (inFltValidxDP && inFltDestxDP) begin
                rsp1ValidxDP <= 1'b1;
                rsp1QxDP     <= MulQxDI;
                rsp1TagxDP   <= inFltTagxDP;
            end else if (rsp1ValidxDP && Rsp1ReadyxSI) begin
                rsp1ValidxDP <= 1'b0;
            end
        end
    end

    assign Rsp0ValidxSO = rsp0ValidxDP;
    assign Rsp0QxDO     = rsp0QxDP;
    assign Rsp0TagxDO   = rsp0TagxDP;
    assign Rsp1ValidxSO = rsp1ValidxDP;
    assign Rsp1QxDO     = rsp1QxDP;
    assign Rsp1TagxDO   = rsp1TagxDP;

endmodule
